// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, instruction opcodes, B_bus
// source encodings, C_bus load bit positions and the sequencer state type.
package cpu_pkg;

  // ALU operation codes (also imported by the ALU)
  localparam logic [3:0] ALU_IDLE   = 4'd0;
  localparam logic [3:0] ALU_ADD    = 4'd1;
  localparam logic [3:0] ALU_SUB    = 4'd2;
  localparam logic [3:0] ALU_LSHFT1 = 4'd3;
  localparam logic [3:0] ALU_LSHFT2 = 4'd4;
  localparam logic [3:0] ALU_LSHFT8 = 4'd5;
  localparam logic [3:0] ALU_RSHFT4 = 4'd6;
  localparam logic [3:0] ALU_PASSA  = 4'd7;
  localparam logic [3:0] ALU_PASSB  = 4'd8;
  localparam logic [3:0] ALU_INC    = 4'd9;
  localparam logic [3:0] ALU_DEC    = 4'd10;

  // Instruction opcodes, IR[7:4]; D and E are undefined
  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LDAC   = 4'h1;
  localparam logic [3:0] OP_STAC   = 4'h2;
  localparam logic [3:0] OP_MVACR  = 4'h3;
  localparam logic [3:0] OP_MVRAC  = 4'h4;
  localparam logic [3:0] OP_ADD    = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_INAC   = 4'h7;
  localparam logic [3:0] OP_DEAC   = 4'h8;
  localparam logic [3:0] OP_LSHFT  = 4'h9;
  localparam logic [3:0] OP_RSHFT4 = 4'hA;
  localparam logic [3:0] OP_JUMP   = 4'hB;
  localparam logic [3:0] OP_JPNZ   = 4'hC;
  localparam logic [3:0] OP_HALT   = 4'hF;

  // B_bus source select
  localparam logic [2:0] BSEL_NONE = 3'd0;
  localparam logic [2:0] BSEL_PC   = 3'd1;
  localparam logic [2:0] BSEL_DR   = 3'd2;
  localparam logic [2:0] BSEL_R    = 3'd3;
  localparam logic [2:0] BSEL_AC   = 3'd4;

  // C_bus load strobe bit positions
  localparam int CLD_PC = 0;
  localparam int CLD_AR = 1;
  localparam int CLD_DR = 2;
  localparam int CLD_IR = 3;
  localparam int CLD_R  = 4;
  localparam int CLD_AC = 5;

  // Sequencer states: fetch, decode, operand fetch, memory execute,
  // single-cycle execute, jump/skip and halt
  typedef enum logic [4:0] {
    S_F1, S_F2, S_F3, S_DEC,
    S_OF1, S_OF2, S_OF3, S_AS,
    S_LD_RD, S_LD_WB, S_ST_DR, S_ST_WR,
    S_MVACR, S_MVRAC, S_ADD, S_SUB, S_INAC, S_DEAC,
    S_LSH1, S_LSH2, S_LSH8, S_RSH4,
    S_JMP, S_SKIP, S_HLT
  } cu_state_e;

endpackage

// File: rtl/control_unit_if.sv
// Sequencer-side bus bundle: IR/flag/memory-ack inputs and the ALU, bus and
// memory control strobes. The illegal flag exists only when
// CU_ILLEGAL_TRAP_EN is defined.
interface control_unit_if #(
  parameter int OPW  = 4,
  parameter int NREG = 6
);
  logic [7:0]      ir_op;
  logic            z_flag;
  logic            mem_ack;
  logic [OPW-1:0]  alu_oper;
  logic [2:0]      b_sel;
  logic [NREG-1:0] c_ld;
  logic            pc_inc;
  logic            mem_rd;
  logic            mem_wr;
  logic            halted;
`ifdef CU_ILLEGAL_TRAP_EN
  logic            illegal;
`endif

  modport master (
    input  ir_op, z_flag, mem_ack,
    output alu_oper, b_sel, c_ld, pc_inc, mem_rd, mem_wr, halted
`ifdef CU_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );

  modport slave (
    output ir_op, z_flag, mem_ack,
    input  alu_oper, b_sel, c_ld, pc_inc, mem_rd, mem_wr, halted
`ifdef CU_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/cu_decode.sv
// Instruction decoder: maps IR and the zero flag to the first execute state.
// Undefined opcodes go to HLT when CU_ILLEGAL_TRAP_EN is defined, otherwise
// they behave as NOP.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir_op,
  input  logic       z_flag,
  output cu_state_e  ex_state
);

`ifdef CU_ILLEGAL_TRAP_EN
  localparam cu_state_e UNDEF_STATE = S_HLT;
`else
  localparam cu_state_e UNDEF_STATE = S_F1;
`endif

  // Select the first execute state from the opcode (and z_flag for JPNZ)
  always_comb begin
    ex_state = UNDEF_STATE;
    case (ir_op[7:4])
      OP_NOP:    ex_state = S_F1;
      OP_LDAC:   ex_state = S_OF1;
      OP_STAC:   ex_state = S_OF1;
      OP_MVACR:  ex_state = S_MVACR;
      OP_MVRAC:  ex_state = S_MVRAC;
      OP_ADD:    ex_state = S_ADD;
      OP_SUB:    ex_state = S_SUB;
      OP_INAC:   ex_state = S_INAC;
      OP_DEAC:   ex_state = S_DEAC;
      OP_LSHFT: begin
        case (ir_op[3:0])
          4'd1:    ex_state = S_LSH1;
          4'd2:    ex_state = S_LSH2;
          4'd8:    ex_state = S_LSH8;
          default: ex_state = UNDEF_STATE;
        endcase
      end
      OP_RSHFT4: ex_state = S_RSH4;
      OP_JUMP:   ex_state = S_OF1;
      OP_JPNZ: begin
        if (z_flag) begin
          ex_state = S_SKIP;
        end else begin
          ex_state = S_OF1;
        end
      end
      OP_HALT:   ex_state = S_HLT;
      default:   ex_state = UNDEF_STATE;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microprogrammed-style sequencer in front of the 24-bit ALU. Fetches and
// decodes instructions and drives ALU op, B_bus select, one-hot C_bus loads
// and memory requests as Moore decodes of the state register. The memory
// ack only qualifies the DR capture/PC increment in a request cycle.
// Optional feature macro: CU_ILLEGAL_TRAP_EN (sticky illegal-opcode trap).
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int NREG = 6
) (
  input logic            clk,
  input logic            reset,
  control_unit_if.master bus
);

  cu_state_e state_q, state_d, ex_state;

  logic [OPW-1:0]  oper_s;
  logic [2:0]      bsel_s;
  logic [NREG-1:0] cld_s;
  logic            pc_inc_s, mem_rd_s, mem_wr_s, halted_s;
  logic [3:0]      opcode_s;

  assign opcode_s = bus.ir_op[7:4];

  function automatic logic [NREG-1:0] ld(input int idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  cu_decode u_decode (
    .ir_op    (bus.ir_op),
    .z_flag   (bus.z_flag),
    .ex_state (ex_state)
  );

  // Next-state logic; every execute path ends back in F1
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_F1:    state_d = S_F2;
      S_F2:    state_d = bus.mem_ack ? S_F3 : S_F2;
      S_F3:    state_d = S_DEC;
      S_DEC:   state_d = ex_state;
      S_OF1:   state_d = S_OF2;
      S_OF2:   state_d = bus.mem_ack ? S_OF3 : S_OF2;
      S_OF3: begin
        if (opcode_s == OP_LDAC || opcode_s == OP_STAC) begin
          state_d = S_AS;
        end else begin
          state_d = S_JMP;
        end
      end
      // One settle cycle with the operand address in AR before the data access
      S_AS: begin
        if (opcode_s == OP_LDAC) begin
          state_d = S_LD_RD;
        end else begin
          state_d = S_ST_DR;
        end
      end
      S_LD_RD: state_d = bus.mem_ack ? S_LD_WB : S_LD_RD;
      S_ST_DR: state_d = S_ST_WR;
      S_ST_WR: state_d = bus.mem_ack ? S_F1 : S_ST_WR;
      S_HLT:   state_d = S_HLT;
      default: state_d = S_F1;
    endcase
  end

  // State register; reset abandons any pending memory request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_F1;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Undefined opcode detected when DEC sends anything but HALT to HLT
  always_comb begin
    if (state_q == S_DEC && state_d == S_HLT && opcode_s != OP_HALT) begin
      illegal_d = 1'b1;
    end else begin
      illegal_d = illegal_q;
    end
  end

  // Sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal = illegal_q;
`endif

  // Output decode from state; forced to zero while reset is asserted
  always_comb begin
    oper_s   = '0;
    bsel_s   = BSEL_NONE;
    cld_s    = '0;
    pc_inc_s = 1'b0;
    mem_rd_s = 1'b0;
    mem_wr_s = 1'b0;
    halted_s = 1'b0;
    if (reset) begin
      halted_s = 1'b0;
    end else begin
      case (state_q)
        S_F1, S_OF1: begin
          bsel_s = BSEL_PC; oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_AR);
        end
        S_F2, S_OF2: begin
          mem_rd_s = 1'b1;
          if (bus.mem_ack) begin
            cld_s = ld(CLD_DR); pc_inc_s = 1'b1;
          end else begin
            cld_s = '0;
          end
        end
        S_F3: begin
          bsel_s = BSEL_DR; oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_IR);
        end
        S_OF3: begin
          bsel_s = BSEL_DR; oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_AR);
        end
        S_LD_RD: begin
          mem_rd_s = 1'b1;
          if (bus.mem_ack) begin
            cld_s = ld(CLD_DR);
          end else begin
            cld_s = '0;
          end
        end
        S_LD_WB, S_MVRAC: begin
          bsel_s = (state_q == S_LD_WB) ? BSEL_DR : BSEL_R;
          oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_AC);
        end
        S_ST_DR: begin
          bsel_s = BSEL_AC; oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_DR);
        end
        S_ST_WR: mem_wr_s = 1'b1;
        S_MVACR: begin
          bsel_s = BSEL_AC; oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_R);
        end
        S_ADD:  begin bsel_s = BSEL_R; oper_s = OPW'(ALU_ADD); cld_s = ld(CLD_AC); end
        S_SUB:  begin bsel_s = BSEL_R; oper_s = OPW'(ALU_SUB); cld_s = ld(CLD_AC); end
        S_INAC: begin oper_s = OPW'(ALU_INC);    cld_s = ld(CLD_AC); end
        S_DEAC: begin oper_s = OPW'(ALU_DEC);    cld_s = ld(CLD_AC); end
        S_LSH1: begin oper_s = OPW'(ALU_LSHFT1); cld_s = ld(CLD_AC); end
        S_LSH2: begin oper_s = OPW'(ALU_LSHFT2); cld_s = ld(CLD_AC); end
        S_LSH8: begin oper_s = OPW'(ALU_LSHFT8); cld_s = ld(CLD_AC); end
        S_RSH4: begin oper_s = OPW'(ALU_RSHFT4); cld_s = ld(CLD_AC); end
        S_JMP: begin
          bsel_s = BSEL_DR; oper_s = OPW'(ALU_PASSB); cld_s = ld(CLD_PC);
        end
        S_SKIP: pc_inc_s = 1'b1;
        S_HLT:  halted_s = 1'b1;
        default: oper_s = '0;
      endcase
    end
  end

  assign bus.alu_oper = oper_s;
  assign bus.b_sel    = bsel_s;
  assign bus.c_ld     = cld_s;
  assign bus.pc_inc   = pc_inc_s;
  assign bus.mem_rd   = mem_rd_s;
  assign bus.mem_wr   = mem_wr_s;
  assign bus.halted   = halted_s;

endmodule

// File: tb/tb_control_unit.sv
// Directed testbench for control_unit. Output vector layout used in the
// expectation tables: {alu_oper[3:0], b_sel[2:0], c_ld[5:0], pc_inc, mem_rd,
// mem_wr, halted}.
module tb_control_unit;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  control_unit_if #(.OPW(4), .NREG(6)) bus ();

  control_unit #(.OPW(4), .NREG(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [16:0] O_ZERO = 17'd0;
  localparam logic [16:0] O_F1   = {4'd8, 3'd1, 6'b000010, 4'b0000};
  localparam logic [16:0] O_RDW  = {4'd0, 3'd0, 6'b000000, 4'b0100};
  localparam logic [16:0] O_F2A  = {4'd0, 3'd0, 6'b000100, 4'b1100};
  localparam logic [16:0] O_RDA  = {4'd0, 3'd0, 6'b000100, 4'b0100};
  localparam logic [16:0] O_F3   = {4'd8, 3'd2, 6'b001000, 4'b0000};
  localparam logic [16:0] O_OF3  = {4'd8, 3'd2, 6'b000010, 4'b0000};
  localparam logic [16:0] O_HLT  = {4'd0, 3'd0, 6'b000000, 4'b0001};

  function automatic logic [16:0] obs();
    return {bus.alu_oper, bus.b_sel, bus.c_ld, bus.pc_inc, bus.mem_rd, bus.mem_wr, bus.halted};
  endfunction

  task automatic test_reset();
    reset = 1'b1; bus.ir_op = 8'h00; bus.z_flag = 1'b0; bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (obs() !== O_ZERO) $display("FAIL reset_outputs got %h exp %h", obs(), O_ZERO);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [16:0] e [5] = '{O_F1, O_F2A, O_F3, O_ZERO, {4'd1, 3'd3, 6'b100000, 4'b0000}};
    bus.ir_op = 8'h50;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = 1'b1; #1;
      total_cnt++;
      if (obs() !== e[i]) $display("FAIL add cyc%0d got %h exp %h", i, obs(), e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL add_next_f1 got %h exp %h", obs(), O_F1);
    else pass_cnt++;
  endtask

  task automatic test_alu_ops();
    logic [7:0]  irs [9] = '{8'h30, 8'h40, 8'h60, 8'h70, 8'h80, 8'h91, 8'h92, 8'h98, 8'hA0};
    logic [16:0] exs [9] = '{
      {4'd8, 3'd4, 6'b010000, 4'b0000}, {4'd8, 3'd3, 6'b100000, 4'b0000},
      {4'd2, 3'd3, 6'b100000, 4'b0000}, {4'd9, 3'd0, 6'b100000, 4'b0000},
      {4'd10, 3'd0, 6'b100000, 4'b0000}, {4'd3, 3'd0, 6'b100000, 4'b0000},
      {4'd4, 3'd0, 6'b100000, 4'b0000}, {4'd5, 3'd0, 6'b100000, 4'b0000},
      {4'd6, 3'd0, 6'b100000, 4'b0000}};
    logic [16:0] e [5];
    for (int k = 0; k < 9; k++) begin
      e = '{O_F1, O_F2A, O_F3, O_ZERO, exs[k]};
      bus.ir_op = irs[k];
      for (int i = 0; i < 5; i++) begin
        bus.mem_ack = 1'b1; #1;
        total_cnt++;
        if (obs() !== e[i]) $display("FAIL alu_op ir=%h cyc%0d got %h exp %h", irs[k], i, obs(), e[i]);
        else pass_cnt++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_nop();
    logic [16:0] e [5] = '{O_F1, O_F2A, O_F3, O_ZERO, O_F1};
    bus.ir_op = 8'h00;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = 1'b1; #1;
      total_cnt++;
      if (obs() !== e[i]) $display("FAIL nop cyc%0d got %h exp %h", i, obs(), e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    // Now in F2 of the next instruction: finish it as a NOP
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'b1; @(posedge clk); #1;
    end
  endtask

  task automatic test_ldac_wait();
    logic [16:0] e [16] = '{O_F1, O_RDW, O_RDW, O_F2A, O_F3, O_ZERO, O_F1, O_RDW,
                            O_RDW, O_F2A, O_OF3, O_ZERO, O_RDW, O_RDW, O_RDA,
                            {4'd8, 3'd2, 6'b100000, 4'b0000}};
    logic        a [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int pulses = 0;
    bus.ir_op = 8'h10;
    for (int i = 0; i < 16; i++) begin
      bus.mem_ack = a[i]; #1;
      if (bus.pc_inc === 1'b1) pulses++;
      total_cnt++;
      if (obs() !== e[i]) $display("FAIL ldac cyc%0d got %h exp %h", i, obs(), e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0; #1;
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL ldac_next_f1 got %h exp %h", obs(), O_F1);
    else pass_cnt++;
    total_cnt++;
    if (pulses !== 2) $display("FAIL ldac_pc_inc_count got %0d exp 2", pulses);
    else pass_cnt++;
  endtask

  task automatic test_stac();
    logic [16:0] e [10] = '{O_F1, O_F2A, O_F3, O_ZERO, O_F1, O_F2A, O_OF3, O_ZERO,
                            {4'd8, 3'd4, 6'b000100, 4'b0000}, {4'd0, 3'd0, 6'b000000, 4'b0010}};
    bus.ir_op = 8'h20;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = 1'b1; #1;
      total_cnt++;
      if (obs() !== e[i]) $display("FAIL stac cyc%0d got %h exp %h", i, obs(), e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL stac_next_f1 got %h exp %h", obs(), O_F1);
    else pass_cnt++;
  endtask

  task automatic test_jpnz();
    logic [16:0] e0 [8] = '{O_F1, O_F2A, O_F3, O_ZERO, O_F1, O_F2A, O_OF3,
                            {4'd8, 3'd2, 6'b000001, 4'b0000}};
    logic [16:0] e1 [5] = '{O_F1, O_F2A, O_F3, O_ZERO, {4'd0, 3'd0, 6'b000000, 4'b1000}};
    bus.ir_op = 8'hC0;
    // z=0 at DEC: acts as JUMP; z rising afterwards must not matter
    for (int i = 0; i < 8; i++) begin
      bus.mem_ack = 1'b1; bus.z_flag = (i > 3); #1;
      total_cnt++;
      if (obs() !== e0[i]) $display("FAIL jpnz_z0 cyc%0d got %h exp %h", i, obs(), e0[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    // z=1 at DEC: single pc_inc skip; z falling afterwards must not matter
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = 1'b1; bus.z_flag = (i <= 3); #1;
      total_cnt++;
      if (obs() !== e1[i]) $display("FAIL jpnz_z1 cyc%0d got %h exp %h", i, obs(), e1[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    bus.z_flag = 1'b0; #1;
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL jpnz_next_f1 got %h exp %h", obs(), O_F1);
    else pass_cnt++;
  endtask

  task automatic test_bad_lshft();
    logic [16:0] e [4] = '{O_F1, O_F2A, O_F3, O_ZERO};
    bus.ir_op = 8'h93;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = 1'b1; #1;
      total_cnt++;
      if (obs() !== e[i]) $display("FAIL bad_lshft cyc%0d got %h exp %h", i, obs(), e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
`ifdef CU_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      bus.mem_ack = i[0]; #1;
      total_cnt++;
      if (obs() !== O_HLT || bus.illegal !== 1'b1)
        $display("FAIL bad_lshft_trap cyc%0d got %h/%b exp %h/1", i, obs(), bus.illegal, O_HLT);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    total_cnt++;
    if (bus.illegal !== 1'b0 || obs() !== O_ZERO)
      $display("FAIL illegal_reset got %h/%b exp %h/0", obs(), bus.illegal, O_ZERO);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0;
`else
    bus.mem_ack = 1'b1; #1;
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL bad_lshft_nop got %h exp %h", obs(), O_F1);
    else pass_cnt++;
    // Complete the following fetch as a NOP so the next test starts in F1
    for (int i = 0; i < 4; i++) begin
      bus.ir_op = 8'h00; bus.mem_ack = 1'b1; @(posedge clk); #1;
    end
`endif
  endtask

  task automatic test_halt();
    logic [16:0] e [4] = '{O_F1, O_F2A, O_F3, O_ZERO};
    bus.ir_op = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = 1'b1; #1;
      total_cnt++;
      if (obs() !== e[i]) $display("FAIL halt cyc%0d got %h exp %h", i, obs(), e[i]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      bus.mem_ack = i[0]; bus.ir_op = 8'h50; #1;
      total_cnt++;
      if (obs() !== O_HLT) $display("FAIL halt_hold cyc%0d got %h exp %h", i, obs(), O_HLT);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    reset = 1'b1; #1;
    total_cnt++;
    if (obs() !== O_ZERO) $display("FAIL halt_reset got %h exp %h", obs(), O_ZERO);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL halt_after_reset got %h exp %h", obs(), O_F1);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_f2();
    bus.ir_op = 8'h50; bus.mem_ack = 1'b0; #1;
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL rst_f2_pre_f1 got %h exp %h", obs(), O_F1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (obs() !== O_RDW) $display("FAIL rst_f2_wait got %h exp %h", obs(), O_RDW);
    else pass_cnt++;
    reset = 1'b1; #1;
    total_cnt++;
    if (obs() !== O_ZERO) $display("FAIL rst_f2_immediate got %h exp %h", obs(), O_ZERO);
    else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    total_cnt++;
    if (obs() !== O_F1) $display("FAIL rst_f2_first_cycle got %h exp %h", obs(), O_F1);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (obs() !== O_RDW) $display("FAIL rst_f2_new_request got %h exp %h", obs(), O_RDW);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_add();
    test_alu_ops();
    test_nop();
    test_ldac_wait();
    test_stac();
    test_jpnz();
    test_bad_lshft();
    test_halt();
    test_reset_mid_f2();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

endmodule
